// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path and a
// stall-and-refill FSM that fetches one line per miss over a beat-valid burst.
module instr_cache #(
    parameter int WIDTH      = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] instr,
    output logic             stall,
    input  logic             flush,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_valid,
    input  logic [WIDTH-1:0] mem_rdata
);
    localparam int OFF   = $clog2(LINE_WORDS);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = WIDTH - IDX - OFF - 2;
    localparam logic [WIDTH-1:0] NOP       = WIDTH'(32'h0000_0013);
    localparam logic [OFF-1:0]   LAST_BEAT = OFF'(LINE_WORDS - 1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t           state_reg;
    logic [OFF-1:0]   beat_reg;
    logic             flush_pending_reg;
    logic [SETS-1:0]  valid_reg;
    logic [SETS-1:0]  valid_next;
    logic [TAG_W-1:0] tag_mem  [SETS];
    logic [WIDTH-1:0] data_mem [SETS][LINE_WORDS];

    logic [OFF-1:0]   pc_word;
    logic [IDX-1:0]   pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic [IDX-1:0]   refill_idx;
    logic [TAG_W-1:0] refill_tag;
    logic             hit;
    logic             beat_fire;
    logic             last_fire;
    logic             set_line;
    logic             unused_pc_bits;

    assign pc_word        = pc[2 +: OFF];
    assign pc_idx         = pc[2+OFF +: IDX];
    assign pc_tag         = pc[WIDTH-1 -: TAG_W];
    assign unused_pc_bits = ^pc[1:0];

    // The refill target comes from the captured line address, not from pc,
    // so a pc that wanders during a stall cannot redirect the refill.
    assign refill_idx = mem_addr[2+OFF +: IDX];
    assign refill_tag = mem_addr[WIDTH-1 -: TAG_W];

    assign hit       = (state_reg == IDLE) && valid_reg[pc_idx] && (tag_mem[pc_idx] == pc_tag);
    assign beat_fire = (state_reg == REFILL) && mem_valid;
    assign last_fire = beat_fire && (beat_reg == LAST_BEAT);
    assign set_line  = last_fire && !flush_pending_reg && !flush;

    always_comb begin
        instr = NOP;
        stall = 1'b1;
        if (hit) begin
            instr = data_mem[pc_idx][pc_word];
            stall = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
            assign valid_next[gi] = flush ? 1'b0 :
                                    (set_line && (refill_idx == IDX'(gi))) ? 1'b1 :
                                    valid_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            beat_reg          <= '0;
            flush_pending_reg <= 1'b0;
            mem_req           <= 1'b0;
            mem_addr          <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!hit) begin
                        state_reg         <= REFILL;
                        mem_req           <= 1'b1;
                        mem_addr          <= {pc_tag, pc_idx, {(OFF+2){1'b0}}};
                        flush_pending_reg <= 1'b0;
                    end
                end
                REFILL: begin
                    if (flush) begin
                        flush_pending_reg <= 1'b1;
                    end
                    if (mem_valid) begin
                        beat_reg <= beat_reg + 1'b1;
                        if (beat_reg == LAST_BEAT) begin
                            state_reg         <= IDLE;
                            mem_req           <= 1'b0;
                            beat_reg          <= '0;
                            flush_pending_reg <= 1'b0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (beat_fire) begin
            data_mem[refill_idx][beat_reg] <= mem_rdata;
            if (last_fire) begin
                tag_mem[refill_idx] <= refill_tag;
            end
        end
    end
endmodule

// File: tb/tb_instr_cache.sv
// Bench for instr_cache: directed scenarios plus randomized fetches checked
// against a line-level model of the cache contents.
module tb_instr_cache;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        stall;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    bit          m_valid [64];
    logic [31:0] m_tag   [64];
    logic [31:0] m_base  [64];

    instr_cache #(.WIDTH(32), .SETS(64), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .instr(instr), .stall(stall), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int m_idx(input logic [31:0] a);
        return int'((a / 16) % 64);
    endfunction

    function automatic void m_flush();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endfunction

    function automatic void m_fill(input logic [31:0] a, input logic [31:0] base, input bit v);
        m_tag[m_idx(a)]   = a / 1024;
        m_base[m_idx(a)]  = base;
        m_valid[m_idx(a)] = v;
    endfunction

    // Plays the memory side for one refill; only observes, callers judge.
    task automatic feed(input logic [31:0] base, input logic [31:0] pattern, input int nbeats,
                        input int flush_beat, output int cycles, output int req_cycles,
                        output logic [31:0] addr_seen, output int stall_low);
        int beat;
        beat = 0; cycles = 0; req_cycles = 0; stall_low = 0; addr_seen = '0;
        while (beat < nbeats) begin
            @(negedge clk);
            mem_valid = (cycles < 32) ? pattern[cycles] : 1'b1;
            flush     = mem_valid && (beat == flush_beat);
            mem_rdata = mem_valid ? base + 32'(beat) : $urandom;
            #1;
            if (mem_req) req_cycles++;
            if (!stall) stall_low++;
            if (cycles == 0) addr_seen = mem_addr;
            else if (mem_addr !== addr_seen) addr_seen = 'x;
            cycles++;
            if (mem_valid) beat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; pc = 32'h100; flush = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", mem_req); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL reset_stall: got %b want 1", stall); end
        vectors++; if (instr !== NOP) begin miscompares++; $display("FAIL reset_instr: got %h want %h", instr, NOP); end
        m_flush();
    endtask

    task automatic test_cold_miss();
        int cyc, rq, sl; logic [31:0] ad;
        @(negedge clk); rst = 1'b1; pc = 32'h100; #1;
        vectors++; if (stall !== 1'b1 || instr !== NOP) begin miscompares++; $display("FAIL cold_c0: got stall=%b instr=%h want 1/%h", stall, instr, NOP); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL cold_c0_req: got %b want 0", mem_req); end
        feed(32'hA0, 32'hFFFF_FFFF, 4, -1, cyc, rq, ad, sl);
        vectors++; if (rq !== 4 || cyc !== 4) begin miscompares++; $display("FAIL cold_req_cycles: got %0d of %0d want 4 of 4", rq, cyc); end
        vectors++; if (ad !== 32'h100) begin miscompares++; $display("FAIL cold_addr: got %h want 00000100", ad); end
        vectors++; if (sl !== 0) begin miscompares++; $display("FAIL cold_stall_during: got %0d low cycles want 0", sl); end
        @(negedge clk); mem_valid = 1'b0; #1;
        vectors++; if (stall !== 1'b0 || instr !== 32'hA0) begin miscompares++; $display("FAIL cold_c5: got stall=%b instr=%h want 0/000000a0", stall, instr); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL cold_c5_req: got %b want 0", mem_req); end
        m_fill(32'h100, 32'hA0, 1'b1);
    endtask

    task automatic test_hit();
        @(negedge clk); pc = 32'h108; #1;
        vectors++; if (stall !== 1'b0 || instr !== 32'hA2) begin miscompares++; $display("FAIL hit_108: got stall=%b instr=%h want 0/000000a2", stall, instr); end
        @(negedge clk); pc = 32'h10F; #1;
        vectors++; if (stall !== 1'b0 || instr !== 32'hA3) begin miscompares++; $display("FAIL hit_10f: got stall=%b instr=%h want 0/000000a3", stall, instr); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL hit_req: got %b want 0", mem_req); end
    endtask

    task automatic test_conflict();
        int cyc, rq, sl; logic [31:0] ad;
        @(negedge clk); pc = 32'h1100; #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL conf_miss: got stall=%b want 1", stall); end
        feed(32'hB0, 32'hFFFF_FFFF, 4, -1, cyc, rq, ad, sl);
        vectors++; if (ad !== 32'h1100) begin miscompares++; $display("FAIL conf_addr: got %h want 00001100", ad); end
        @(negedge clk); mem_valid = 1'b0; #1;
        vectors++; if (stall !== 1'b0 || instr !== 32'hB0) begin miscompares++; $display("FAIL conf_hit: got stall=%b instr=%h want 0/000000b0", stall, instr); end
        m_fill(32'h1100, 32'hB0, 1'b1);
        @(negedge clk); pc = 32'h100; #1;
        vectors++; if (stall !== 1'b1 || instr !== NOP) begin miscompares++; $display("FAIL conf_refetch: got stall=%b instr=%h want 1/%h", stall, instr, NOP); end
        feed(32'hA0, 32'hFFFF_FFFF, 4, -1, cyc, rq, ad, sl);
        vectors++; if (ad !== 32'h100) begin miscompares++; $display("FAIL conf_readdr: got %h want 00000100", ad); end
        @(negedge clk); mem_valid = 1'b0; #1;
        vectors++; if (stall !== 1'b0 || instr !== 32'hA0) begin miscompares++; $display("FAIL conf_rehit: got stall=%b instr=%h want 0/000000a0", stall, instr); end
        m_fill(32'h100, 32'hA0, 1'b1);
    endtask

    task automatic test_gapped();
        int cyc, rq, sl; logic [31:0] ad;
        @(negedge clk); pc = 32'h200; #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL gap_miss: got stall=%b want 1", stall); end
        feed(32'hC0, 32'b1011001, 4, -1, cyc, rq, ad, sl);
        vectors++; if (cyc !== 7 || rq !== 7) begin miscompares++; $display("FAIL gap_cycles: got %0d req of %0d want 7 of 7", rq, cyc); end
        vectors++; if (ad !== 32'h200 || sl !== 0) begin miscompares++; $display("FAIL gap_addr: got %h low=%0d want 00000200 low=0", ad, sl); end
        m_fill(32'h200, 32'hC0, 1'b1);
        for (int w = 0; w < 4; w++) begin
            @(negedge clk); mem_valid = 1'b0; mem_rdata = $urandom; pc = 32'h200 + 32'(4 * w); #1;
            vectors++; if (stall !== 1'b0 || instr !== 32'hC0 + 32'(w)) begin miscompares++; $display("FAIL gap_word%0d: got stall=%b instr=%h want 0/%h", w, stall, instr, 32'hC0 + 32'(w)); end
        end
    endtask

    task automatic test_flush_refill();
        int cyc, rq, sl; logic [31:0] ad;
        @(negedge clk); pc = 32'h300; #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL fl_miss: got stall=%b want 1", stall); end
        feed(32'hD0, 32'hFFFF_FFFF, 4, 2, cyc, rq, ad, sl);
        m_flush(); m_fill(32'h300, 32'hD0, 1'b0);
        @(negedge clk); mem_valid = 1'b0; flush = 1'b0; #1;
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL fl_req_fall: got %b want 0", mem_req); end
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL fl_line_invalid: got stall=%b want 1", stall); end
        feed(32'hD4, 32'hFFFF_FFFF, 4, -1, cyc, rq, ad, sl);
        vectors++; if (ad !== 32'h300 || rq !== cyc) begin miscompares++; $display("FAIL fl_rereq: got addr=%h req=%0d/%0d want 00000300 req every cycle", ad, rq, cyc); end
        @(negedge clk); mem_valid = 1'b0; #1;
        vectors++; if (stall !== 1'b0 || instr !== 32'hD4) begin miscompares++; $display("FAIL fl_rehit: got stall=%b instr=%h want 0/000000d4", stall, instr); end
        m_fill(32'h300, 32'hD4, 1'b1);
        @(negedge clk); pc = 32'h200; #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL fl_other_line: got stall=%b want 1", stall); end
        feed(32'hC8, 32'hFFFF_FFFF, 4, -1, cyc, rq, ad, sl);
        @(negedge clk); mem_valid = 1'b0; #1;
        vectors++; if (stall !== 1'b0 || instr !== 32'hC8) begin miscompares++; $display("FAIL fl_other_refill: got stall=%b instr=%h want 0/000000c8", stall, instr); end
        m_fill(32'h200, 32'hC8, 1'b1);
    endtask

    task automatic test_reset_mid_refill();
        int cyc, rq, sl; logic [31:0] ad;
        @(negedge clk); pc = 32'h204; #1;
        vectors++; if (stall !== 1'b0 || instr !== 32'hC9) begin miscompares++; $display("FAIL rmr_prehit: got stall=%b instr=%h want 0/000000c9", stall, instr); end
        @(negedge clk); pc = 32'h400; #1;
        feed(32'hE0, 32'hFFFF_FFFF, 2, -1, cyc, rq, ad, sl);
        @(negedge clk); mem_valid = 1'b0; #1;
        vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rmr_in_refill: got req=%b want 1", mem_req); end
        #2 rst = 1'b0; #1;
        vectors++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin miscompares++; $display("FAIL rmr_async: got req=%b addr=%h want 0/00000000", mem_req, mem_addr); end
        m_flush();
        @(negedge clk); rst = 1'b1; pc = 32'h204; mem_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
        vectors++; if (stall !== 1'b1 || instr !== NOP) begin miscompares++; $display("FAIL rmr_miss: got stall=%b instr=%h want 1/%h", stall, instr, NOP); end
        feed(32'hF0, 32'hFFFF_FFFF, 4, -1, cyc, rq, ad, sl);
        vectors++; if (ad !== 32'h200 || cyc !== 4) begin miscompares++; $display("FAIL rmr_refill: got addr=%h cycles=%0d want 00000200/4", ad, cyc); end
        m_fill(32'h200, 32'hF0, 1'b1);
        for (int w = 1; w >= 0; w--) begin
            @(negedge clk); mem_valid = 1'b0; pc = 32'h200 + 32'(4 * w); #1;
            vectors++; if (stall !== 1'b0 || instr !== 32'hF0 + 32'(w)) begin miscompares++; $display("FAIL rmr_word%0d: got stall=%b instr=%h want 0/%h", w, stall, instr, 32'hF0 + 32'(w)); end
        end
    endtask

    task automatic test_random();
        int cyc, rq, sl, idx, fb, tries;
        logic [31:0] ad, pc_v, base, line;
        bit exp_hit, do_flush;
        for (int n = 0; n < 80; n++) begin
            pc_v = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
                   (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            idx = m_idx(pc_v);
            line = pc_v & ~32'hF;
            exp_hit = m_valid[idx] && (m_tag[idx] == pc_v / 1024);
            do_flush = ($urandom_range(0, 7) == 0);
            @(negedge clk); pc = pc_v; flush = do_flush; mem_valid = $urandom_range(0, 1); mem_rdata = $urandom; #1;
            vectors++;
            if (stall !== !exp_hit || instr !== (exp_hit ? m_base[idx] + 32'(pc_v[3:2]) : NOP)) begin
                miscompares++;
                $display("FAIL rnd_fetch pc=%h: got stall=%b instr=%h want %b/%h", pc_v, stall, instr, !exp_hit, exp_hit ? m_base[idx] + 32'(pc_v[3:2]) : NOP);
            end
            if (do_flush) m_flush();
            tries = 0;
            while (!exp_hit && tries < 3) begin
                fb = (tries == 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1;
                base = $urandom;
                feed(base, $urandom, 4, fb, cyc, rq, ad, sl);
                vectors++;
                if (ad !== line || rq !== cyc || sl !== 0) begin
                    miscompares++;
                    $display("FAIL rnd_refill pc=%h: got addr=%h req=%0d/%0d low=%0d want %h every cycle low=0", pc_v, ad, rq, cyc, sl, line);
                end
                if (fb >= 0) m_flush();
                m_fill(pc_v, base, fb < 0);
                @(negedge clk); mem_valid = 1'b0; flush = 1'b0; #1;
                exp_hit = m_valid[idx];
                vectors++;
                if (mem_req !== 1'b0 || stall !== !exp_hit || (exp_hit && instr !== base + 32'(pc_v[3:2]))) begin
                    miscompares++;
                    $display("FAIL rnd_after pc=%h: got req=%b stall=%b instr=%h want 0/%b/%h", pc_v, mem_req, stall, instr, !exp_hit, base + 32'(pc_v[3:2]));
                end
                tries++;
            end
        end
        @(negedge clk); flush = 1'b0; mem_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_gapped();
        test_flush_refill();
        test_reset_mid_refill();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only instruction cache between the program counter and the backing instruction memory. It supplies `instr` to decode/control combinationally on a hit. On a miss it stalls the core and refills one line through a multi-beat request/valid burst from a slow memory port. Supports whole-cache invalidation for `fence.i`.

## Interface

**Parameters**
- `WIDTH`, 32: address and instruction width.
- `SETS`, 64: number of lines; power of two, at least 2.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, at least 2.

**Ports**
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `pc`, in, WIDTH: fetch byte address; bits [1:0] are ignored.
- `instr`, out, WIDTH: fetched instruction.
- `stall`, out, 1: core must hold `pc` and must not commit state while high.
- `flush`, in, 1: one-cycle pulse that invalidates all lines.
- `mem_req`, out, 1: line refill request; a registered output.
- `mem_addr`, out, WIDTH: line-aligned byte address of the refill; a registered output.
- `mem_valid`, in, 1: the current beat on `mem_rdata` is valid.
- `mem_rdata`, in, WIDTH: refill data. Words arrive in ascending order, word 0 first.

## Operation

**Address split** (OFF = log2(LINE_WORDS), IDX = log2(SETS))
- byte offset = `pc[1:0]`
- word = `pc[2+OFF-1:2]`
- index = next IDX bits
- tag = remaining upper bits

**Storage**
- Per set: valid bit, tag, and LINE_WORDS data words.
- Arrays are flops with asynchronous read.
- Only the valid bits are reset; tag and data contents are don't-care after reset.

**Hit**
- Condition: state is IDLE, `valid[index]` is set, and `tag[index]` equals the pc tag.
- Outputs: `instr` = `data[index][word]`, `stall` = 0.

**Miss** (in IDLE)
- `stall` = 1 and `instr` = 32'h0000_0013 (NOP) in the same cycle.
- Capture the line address {tag, index, OFF+2 zero bits} into `mem_addr`.
- Next state is REFILL.

**FSM states**
- IDLE
  - miss -> REFILL
  - otherwise stay in IDLE
- REFILL
  - `mem_req` = 1 and `stall` = 1.
  - Each edge with `mem_valid` = 1 writes `mem_rdata` into `data[index][beat]` and increments the beat counter (width OFF).
  - On the edge accepting beat LINE_WORDS-1: write the tag, set `valid[index]` unless a flush is pending, clear the counter, go to IDLE.
  - Cycles with `mem_valid` = 0 hold all state.

**Flush**
- Clears every valid bit on the edge where `flush` = 1, in any state.
- If asserted in REFILL, or in the cycle of the final beat, set `flush_pending`. The refill completes but the line is not marked valid, and `flush_pending` clears.
- A flush asserted in the same cycle as a hit still returns the hit data that cycle.

**Rules and boundaries**
- Memory must deliver exactly LINE_WORDS beats per request. Any `mem_valid` in IDLE is ignored.
- Conflict miss (same index, different tag): the old line is overwritten. Its valid bit stays set during the refill, but no hits are possible because the FSM is not in IDLE.
- `pc` changing while `stall` = 1 is a protocol violation. The refill still targets the captured `mem_addr` and index.
- Reset mid-refill: immediately return to IDLE, `mem_req` = 0, counter = 0, all valid bits = 0, `flush_pending` = 0. Late beats after reset are ignored.

## Timing

**Reset values**
- `mem_req` = 0, `mem_addr` = 0, state = IDLE, counter = 0, all valid bits = 0.
- Right after reset, `stall` = 1 and `instr` = NOP, because the first fetch misses.

**Hit latency**
- 0 cycles: `instr` is combinational from `pc`.

**Miss**
- Miss detected in cycle 0.
- `mem_req` = 1 from cycle 1.
- If `mem_valid` is high in cycles k .. k+LINE_WORDS-1, `mem_req` falls and `stall` = 0 in cycle k+LINE_WORDS, with the hit served that cycle.
- Minimum penalty is 1 + LINE_WORDS cycles.

**Handshake**
- `mem_req` and `mem_addr` stay stable for the whole REFILL.
- `mem_req` drops combinationally-free, as a registered output, in the cycle after the last beat.
- The next request is issued no earlier than 1 cycle after that.

## Test plan

1. **Cold miss.** Release reset, `pc` = 0x0000_0100, memory returns 0xA0,0xA1,0xA2,0xA3 on consecutive cycles starting in cycle 1.
   - `mem_addr` = 0x100, `mem_req` high in cycles 1-4.
   - `stall` = 0 in cycle 5 with `instr` = 0xA0.
2. **Hit after refill.** After test 1, `pc` = 0x108.
   - `instr` = 0xA2 in the same cycle, `stall` = 0, `mem_req` stays 0.
3. **Conflict miss.** With SETS = 64 and LINE_WORDS = 4, fetch 0x100 then 0x1100 (same index, new tag).
   - Second fetch refills from `mem_addr` = 0x1100.
   - Re-fetching 0x100 misses again.
4. **Gapped beats.** Drive `mem_valid` as 1,0,0,1,1,0,1.
   - 4 beats are accepted in the correct word slots.
   - `stall` falls the cycle after the 7th pattern cycle.
5. **Flush during refill.** Pulse `flush` during beat 2 of 4.
   - The refill completes and `mem_req` falls.
   - The line stays invalid and the same `pc` issues a new request.
   - A previously valid unrelated line also misses.
6. **Reset mid-refill.** Assert `rst` low after beat 1.
   - `mem_req` = 0 immediately, asynchronously.
   - After release, a previously hitting `pc` misses and a new refill restarts at word 0.
